shift_add_multiplier: RTL and testbench
=======================================

SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 SHALL have no parameters; operand width is fixed at 16 bits and product width at 32 bits.
REQ-002 SHALL provide port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL provide port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL provide port start, input, 1: request to begin a multiply; sampled only in IDLE.
REQ-005 SHALL provide port a, input, 16: unsigned multiplicand, captured when start is accepted.
REQ-006 SHALL provide port b, input, 16: unsigned multiplier, captured when start is accepted.
REQ-007 SHALL provide port product, output, 32: registered result, valid from done until the next accepted start.
REQ-008 SHALL provide port busy, output, 1: high while in RUN.
REQ-009 SHALL provide port done, output, 1: single-cycle pulse marking that product is valid.

Function
REQ-010 SHALL implement three states: IDLE, RUN and DONE.
REQ-011 In IDLE with start=1 at edge N, SHALL latch a into mcand, latch b into mplier, clear acc and cnt, and enter RUN.
REQ-012 In RUN, each edge SHALL update acc <= acc + (zero-extended pp << cnt), where pp is the 16-bit AND of mcand with mplier[0].
REQ-013 In RUN, each edge SHALL also shift mplier right by one (zero fill) and increment the 4-bit cnt.
REQ-014 All arithmetic SHALL be unsigned and 32-bit; no overflow is possible, and 0xFFFF*0xFFFF yields 0xFFFE0001.
REQ-015 On the RUN edge where cnt=15 (edge N+16), SHALL enter DONE, load product with the final acc, and assert done.
REQ-016 Latency from the start-accepting edge to done-high SHALL be 16 cycles; done SHALL stay high exactly one cycle.
REQ-017 DONE SHALL return to IDLE on the next edge unconditionally.
REQ-018 start SHALL be ignored in RUN and DONE: no re-latch, no queuing.
REQ-019 a and b SHALL be don't-care except on the edge that accepts start.
REQ-020 product SHALL hold its last value through IDLE and RUN until the next DONE load.
REQ-021 busy SHALL be 1 exactly in RUN.

Reset
REQ-022 rst_n=0 SHALL immediately force state=IDLE, product=0, done=0, busy=0, and clear acc, mcand, mplier and cnt.
REQ-023 Reset asserted mid-RUN SHALL abort the operation with no done pulse; the first start after rst_n rises SHALL behave as from power-up.

Configuration
REQ-024 Macro MULT_EARLY_TERM_EN, when defined: a RUN edge whose post-shift mplier is zero SHALL go directly to DONE, loading product with the updated acc.
REQ-025 With MULT_EARLY_TERM_EN defined, done SHALL follow the start edge by 1 to 16 cycles (b=0 or b=1: 1 cycle).
REQ-026 With MULT_EARLY_TERM_EN undefined: always 16 RUN cycles, per REQ-015.

Structure
REQ-027 Shared package calc_pkg SHALL hold OPND_W=16, PROD_W=32 and the state enumeration (IDLE, RUN, DONE).
REQ-028 The partial product SHALL come from one instance of the existing andmultiply sub-module (mplier[0] to B, mcand to A).
REQ-029 No other sub-modules SHALL be used.

Verification
REQ-030 a=3, b=5, start pulse -> busy for 16 cycles, done after 16 cycles, product=0x0000000F.
REQ-031 a=0xFFFF, b=0xFFFF -> product=0xFFFE0001 with a single done pulse.
REQ-032 start held high during RUN with a=7, b=9 changing to a=1, b=1 mid-run -> single result 63; no second operation starts until back in IDLE.
REQ-033 rst_n low at cycle 8 of RUN -> product=0, busy=0, no done; next run a=2, b=4 -> product=8.
REQ-034 a=0x1234, b=0x0001 -> done after 16 cycles without MULT_EARLY_TERM_EN, after 1 cycle with it; product=0x00001234 in both cases.
REQ-035 Back-to-back: start asserted on the cycle after done (state IDLE) with a=10, b=10 -> accepted, product=100, previous product held until then.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared widths and state encoding for the shift-add multiplier.
package calc_pkg;

  localparam int OPND_W = 16;
  localparam int PROD_W = 32;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/andmultiply.sv
// Partial-product generator: every bit of A gated by the single bit B.
module andmultiply
  import calc_pkg::*;
(
  input  logic [OPND_W-1:0] A,
  input  logic              B,
  output logic [OPND_W-1:0] Y
);

  assign Y = A & {OPND_W{B}};

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential 16x16 unsigned shift-add multiplier, one multiplier bit per cycle.
// Optional MULT_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are all zero.
module shift_add_multiplier
  import calc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [OPND_W-1:0] a,
  input  logic [OPND_W-1:0] b,
  output logic [PROD_W-1:0] product,
  output logic              busy,
  output logic              done
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [OPND_W-1:0]   r_mcand;
  logic [OPND_W-1:0]   r_mplier;
  logic [PROD_W-1:0]   r_acc;
  logic [PROD_W-1:0]   r_product;
  logic [CNT_W-1:0]    r_cnt;
  logic [OPND_W-1:0]   w_pp;
  logic [OPND_W-1:0]   w_mplier_shr;
  logic [PROD_W-1:0]   w_acc_nxt;
  logic                w_last;

  andmultiply u_andmultiply (
    .A (r_mcand),
    .B (r_mplier[0]),
    .Y (w_pp)
  );

  assign w_acc_nxt    = r_acc + (PROD_W'(w_pp) << r_cnt);
  assign w_mplier_shr = r_mplier >> 1;

`ifdef MULT_EARLY_TERM_EN
  assign w_last = (r_cnt == CNT_W'(OPND_W - 1)) || (w_mplier_shr == '0);
`else
  assign w_last = (r_cnt == CNT_W'(OPND_W - 1));
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operands are only captured on the accepting edge; start elsewhere is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mcand  <= a;
            r_mplier <= b;
            r_acc    <= '0;
            r_cnt    <= '0;
          end
        end
        RUN: begin
          r_acc    <= w_acc_nxt;
          r_mplier <= w_mplier_shr;
          r_cnt    <= r_cnt + 1'b1;
          if (w_last) r_product <= w_acc_nxt;
        end
        default: ;
      endcase
    end
  end

  assign product = r_product;
  assign busy    = (r_state == RUN);
  assign done    = (r_state == DONE);

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier; honours MULT_EARLY_TERM_EN for latency expectations.
module tb_shift_add_multiplier;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic [31:0] product;
  logic        busy;
  logic        done;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] sb_q[$];
  logic [31:0] last_prod = '0;
  logic        prev_done = 1'b0;

  shift_add_multiplier dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .product (product),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input logic [15:0] bb);
`ifdef MULT_EARLY_TERM_EN
    int n = 1;
    for (int i = 1; i < 16; i++) if ((bb >> i) != 16'd0) n = i + 1;
    return n;
`else
    return 16;
`endif
  endfunction

  // Scoreboard side: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (prev_done) chk("done_width", 32'd1, 32'd0);
      if (sb_q.size() == 0) chk("spurious_done", 32'd1, 32'd0);
      else chk("product", product, sb_q.pop_front());
    end
    prev_done <= done;
  end

  task automatic run_op(input logic [15:0] ia, input logic [15:0] ib);
    int          j;
    int          nb;
    logic [31:0] exp;
    exp = 32'(ia) * 32'(ib);
    @(negedge clk);
    a = ia; b = ib; start = 1'b1;
    sb_q.push_back(exp);
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    nb = 0;
    for (j = 0; j < 40; j++) begin
      @(negedge clk);
      if (j == 0) chk("hold_prod", product, last_prod);
      if (done) break;
      if (busy) nb++;
    end
    chk("latency", 32'(j), 32'(exp_lat(ib)));
    chk("busy_cycles", 32'(nb), 32'(exp_lat(ib)));
    chk("busy_in_done", 32'(busy), 32'd0);
    last_prod = exp;
  endtask

  initial begin
    int j;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_product", product, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(16'd3, 16'd5);
    run_op(16'hFFFF, 16'hFFFF);
    run_op(16'h1234, 16'h0001);
    run_op(16'hABCD, 16'h0000);
    run_op(16'd10, 16'd10);
    for (int k = 0; k < 4; k++) run_op(16'($urandom), 16'($urandom));

    // start held high through the run with operands changing mid-way
    @(negedge clk);
    a = 16'd7; b = 16'd9; start = 1'b1;
    sb_q.push_back(32'd63);
    @(posedge clk);
    for (j = 0; j < 40; j++) begin
      @(negedge clk);
      if (j == 4) begin a = 16'd1; b = 16'd1; end
      if (done) break;
    end
    chk("held_latency", 32'(j), 32'(exp_lat(16'd9)));
    start = 1'b0;
    last_prod = 32'd63;
    @(negedge clk);
    chk("held_no_restart", 32'(busy), 32'd0);
    chk("held_queue_empty", 32'(sb_q.size()), 32'd0);

    // reset during RUN aborts with no done pulse
    @(negedge clk);
    a = 16'd5; b = 16'h8006; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_product", product, 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_prod = 32'd0;
    run_op(16'd2, 16'd4);

    // back-to-back after the run above
    run_op(16'd10, 16'd10);
    repeat (3) @(negedge clk);
    chk("final_hold", product, 32'd100);
    chk("queue_drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
